ddfs_multi_core: RTL and testbench

DDFS_MULTI_CORE -- requirements
Module: ddfs_multi_core

---
 rtl/ddfs_multi_core.sv | 166 ++++++++++++++++
 tb/tb_ddfs_multi_core.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_multi_core.sv
// ddfs_multi_core: time-multiplexed multi-channel I/Q direct digital synthesizer.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   sample_en            frame strobe; starts one pass over all channels
//   phase_sync           with an accepted strobe, zeroes every phase
//   tw_wr_en/ch/data     tuning-word write into a channel's shadow register
//   sine_out, cosine_out signed Q/I sample of channel out_ch
//   valid_out            sample outputs valid
//   busy                 frame in progress
//   overrun              one-cycle pulse for a dropped strobe
module ddfs_multi_core #(
  parameter int NUM_CH     = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int PHASE_BITS = 10,
  parameter int LUT_BITS   = 18,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_en,
  input  logic                       phase_sync,
  input  logic                       tw_wr_en,
  input  logic [CH_W-1:0]            tw_wr_ch,
  input  logic [ACC_WIDTH-1:0]       tw_wr_data,
  output logic signed [LUT_BITS-1:0] cosine_out,
  output logic signed [LUT_BITS-1:0] sine_out,
  output logic [CH_W-1:0]            out_ch,
  output logic                       valid_out,
  output logic                       busy,
  output logic                       overrun
);

  localparam int K_W = PHASE_BITS - 2;
  localparam int N   = 1 << K_W;
  localparam logic [PHASE_BITS-1:0] QTR = PHASE_BITS'(N);

  // Elaboration-time quarter-wave sample, Taylor series in double precision.
  function automatic int quarter_sin(input int k);
    real x;
    real term;
    real s;
    real amp;
    amp  = real'((64'd1 << (LUT_BITS - 1)) - 64'd1);
    x    = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5)
           / real'(64'd1 << PHASE_BITS);
    term = x;
    s    = x;
    for (int i = 1; i < 14; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      s    = s + term;
    end
    return $rtoi(amp * s + 0.5);
  endfunction

  logic [LUT_BITS-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam int V = quarter_sin(k);
    assign rom[k] = LUT_BITS'(V);
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [ACC_WIDTH-1:0]  acc    [NUM_CH];
  logic [ACC_WIDTH-1:0]  tw_act [NUM_CH];
  logic [ACC_WIDTH-1:0]  tw_sh  [NUM_CH];
  logic [CH_W-1:0]       ch;
  logic [CH_W-1:0]       s1_ch;
  logic [PHASE_BITS-1:0] s1_p;
  logic                  s1_valid;
  logic                  sync_frame;
  logic                  accept;

  assign accept = sample_en && !busy && (state == IDLE);

  // Quadrant fold of the quarter-wave table; cosine is sine a quarter ahead.
  logic [PHASE_BITS-1:0]       cos_p;
  logic [K_W-1:0]              sin_k;
  logic [K_W-1:0]              cos_k;
  logic [LUT_BITS-1:0]         sin_mag;
  logic [LUT_BITS-1:0]         cos_mag;
  logic signed [LUT_BITS-1:0]  sin_val;
  logic signed [LUT_BITS-1:0]  cos_val;

  always_comb begin
    cos_p   = s1_p + QTR;
    sin_k   = s1_p[K_W-1:0];
    cos_k   = cos_p[K_W-1:0];
    sin_mag = rom[s1_p[PHASE_BITS-2] ? ~sin_k : sin_k];
    cos_mag = rom[cos_p[PHASE_BITS-2] ? ~cos_k : cos_k];
    sin_val = s1_p[PHASE_BITS-1] ?
              -$signed(sin_mag) : $signed(sin_mag);
    cos_val = cos_p[PHASE_BITS-1] ?
              -$signed(cos_mag) : $signed(cos_mag);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ch         <= '0;
      s1_ch      <= '0;
      s1_p       <= '0;
      s1_valid   <= 1'b0;
      sync_frame <= 1'b0;
      sine_out   <= '0;
      cosine_out <= '0;
      out_ch     <= '0;
      valid_out  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]    <= '0;
        tw_act[i] <= '0;
        tw_sh[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tw_wr_en && tw_wr_ch == CH_W'(i))
          tw_sh[i] <= tw_wr_data;
      end
      overrun  <= sample_en && busy;
      busy     <= accept || (state == RUN) || s1_valid;
      s1_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= RUN;
            ch         <= '0;
            sync_frame <= phase_sync;
            // a write landing on this edge must reach the active word too
            for (int i = 0; i < NUM_CH; i++) begin
              if (tw_wr_en && tw_wr_ch == CH_W'(i))
                tw_act[i] <= tw_wr_data;
              else
                tw_act[i] <= tw_sh[i];
            end
          end
        end
        RUN: begin
          s1_valid <= 1'b1;
          s1_ch    <= ch;
          if (sync_frame) begin
            s1_p    <= '0;
            acc[ch] <= tw_act[ch];
          end else begin
            s1_p    <= acc[ch][ACC_WIDTH-1 -: PHASE_BITS];
            acc[ch] <= acc[ch] + tw_act[ch];
          end
          if (ch == CH_W'(NUM_CH - 1))
            state <= IDLE;
          else
            ch <= ch + 1'b1;
        end
        default: state <= IDLE;
      endcase
      valid_out <= s1_valid;
      if (s1_valid) begin
        sine_out   <= sin_val;
        cosine_out <= cos_val;
        out_ch     <= s1_ch;
      end
    end
  end

endmodule

// File: tb/tb_ddfs_multi_core.sv
// tb_ddfs_multi_core: randomized self-checking bench for ddfs_multi_core.
// Reference model works directly from phase angles with $sin/$cos.
module tb_ddfs_multi_core;

  localparam int NUM_CH = 4;
  localparam int ACC_W  = 24;
  localparam int PB     = 10;
  localparam int LB     = 18;
  localparam int NC     = NUM_CH + 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sample_en = 1'b0;
  logic              phase_sync = 1'b0;
  logic              tw_wr_en = 1'b0;
  logic [1:0]        tw_wr_ch = '0;
  logic [ACC_W-1:0]  tw_wr_data = '0;
  logic signed [LB-1:0] cosine_out;
  logic signed [LB-1:0] sine_out;
  logic [1:0]        out_ch;
  logic              valid_out;
  logic              busy;
  logic              overrun;

  ddfs_multi_core #(
    .NUM_CH(NUM_CH), .ACC_WIDTH(ACC_W),
    .PHASE_BITS(PB), .LUT_BITS(LB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_en(sample_en), .phase_sync(phase_sync),
    .tw_wr_en(tw_wr_en), .tw_wr_ch(tw_wr_ch),
    .tw_wr_data(tw_wr_data),
    .cosine_out(cosine_out), .sine_out(sine_out),
    .out_ch(out_ch), .valid_out(valid_out),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ACC_W-1:0] m_acc [NUM_CH];
  logic [ACC_W-1:0] m_act [NUM_CH];
  logic [ACC_W-1:0] m_sh  [NUM_CH];
  int e_sin [NUM_CH];
  int e_cos [NUM_CH];

  bit c_v    [NC];
  int c_ch   [NC];
  int c_sin  [NC];
  int c_cos  [NC];
  bit c_busy [NC];
  bit c_ovr  [NC];

  function automatic int wave(input int p, input bit is_cos);
    real th;
    real v;
    th = 2.0 * 3.14159265358979323846 * (real'(p) + 0.5)
         / real'(1 << PB);
    v = 131071.0 * (is_cos ? $cos(th) : $sin(th));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = '0;
      m_act[i] = '0;
      m_sh[i]  = '0;
    end
  endtask

  task automatic model_frame(input bit sync);
    int p;
    for (int i = 0; i < NUM_CH; i++) m_act[i] = m_sh[i];
    for (int i = 0; i < NUM_CH; i++) begin
      p = sync ? 0 : int'(m_acc[i] >> (ACC_W - PB));
      e_sin[i] = wave(p, 1'b0);
      e_cos[i] = wave(p, 1'b1);
      m_acc[i] = sync ? m_act[i] : m_acc[i] + m_act[i];
    end
  endtask

  task automatic write_tw(input int ch, input logic [ACC_W-1:0] d);
    tw_wr_en   = 1'b1;
    tw_wr_ch   = 2'(ch);
    tw_wr_data = d;
    @(posedge clk); #1;
    tw_wr_en = 1'b0;
    m_sh[ch] = d;
  endtask

  // Starts just after an edge; strobes a frame and records every cycle.
  // co_en: write on the accepting edge; wr_at/se_at: cycle of extra
  // write / extra strobe (-1 = none).
  task automatic run_frame(
    input bit sync,
    input bit co_en, input int co_ch, input logic [ACC_W-1:0] co_d,
    input int wr_at, input int wr_ch, input logic [ACC_W-1:0] wr_d,
    input int se_at
  );
    sample_en  = 1'b1;
    phase_sync = sync;
    if (co_en) begin
      tw_wr_en   = 1'b1;
      tw_wr_ch   = 2'(co_ch);
      tw_wr_data = co_d;
    end
    for (int c = 0; c < NC; c++) begin
      @(posedge clk); #1;
      sample_en  = 1'b0;
      phase_sync = 1'b0;
      tw_wr_en   = 1'b0;
      c_v[c]    = valid_out;
      c_ch[c]   = int'(out_ch);
      c_sin[c]  = int'(sine_out);
      c_cos[c]  = int'(cosine_out);
      c_busy[c] = busy;
      c_ovr[c]  = overrun;
      if (c == wr_at) begin
        tw_wr_en   = 1'b1;
        tw_wr_ch   = 2'(wr_ch);
        tw_wr_data = wr_d;
      end
      if (c == se_at) begin
        sample_en  = 1'b1;
        phase_sync = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sample_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags got v=%b b=%b o=%b want 0 0 0",
               valid_out, busy, overrun);
    end
    n_cmp++;
    if (sine_out !== 0 || cosine_out !== 0 || out_ch !== 0) begin
      n_bad++;
      $display("FAIL reset_data got s=%0d c=%0d ch=%0d want 0",
               sine_out, cosine_out, out_ch);
    end
    sample_en = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_zero_tw();
    model_frame(1'b0);
    run_frame(1'b0, 1'b0, 0, '0, -1, 0, '0, -1);
    n_cmp++;
    if (c_busy[0] !== 1'b1 || c_v[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_start got busy=%b v1=%b want 1 0",
               c_busy[0], c_v[1]);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      n_cmp++;
      if (c_v[i+2] !== 1'b1 || c_ch[i+2] !== i ||
          c_sin[i+2] !== 402 || c_cos[i+2] !== 131070) begin
        n_bad++;
        $display("FAIL zero_ch%0d got v=%b ch=%0d s=%0d c=%0d want 1 %0d 402 131070",
                 i, c_v[i+2], c_ch[i+2], c_sin[i+2], c_cos[i+2], i);
      end
    end
    n_cmp++;
    if (c_v[NC-1] !== 1'b0 || c_busy[NC-2] !== 1'b1 ||
        c_busy[NC-1] !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_end got v=%b busy=%b%b want 0 10",
               c_v[NC-1], c_busy[NC-2], c_busy[NC-1]);
    end
  endtask

  task automatic test_quarter();
    int rs [3];
    int rc [3];
    rs = '{402, 131070, -402};
    rc = '{131070, -402, -131070};
    write_tw(0, 24'h400000);
    for (int f = 0; f < 3; f++) begin
      model_frame(1'b0);
      run_frame(1'b0, 1'b0, 0, '0, -1, 0, '0, -1);
      n_cmp++;
      if (c_sin[2] !== rs[f] || c_cos[2] !== rc[f]) begin
        n_bad++;
        $display("FAIL quarter_f%0d got s=%0d c=%0d want %0d %0d",
                 f, c_sin[2], c_cos[2], rs[f], rc[f]);
      end
      for (int i = 1; i < NUM_CH; i++) begin
        n_cmp++;
        if (c_sin[i+2] !== e_sin[i] || c_cos[i+2] !== e_cos[i]) begin
          n_bad++;
          $display("FAIL quarter_f%0d_ch%0d got %0d %0d want %0d %0d",
                   f, i, c_sin[i+2], c_cos[i+2], e_sin[i], e_cos[i]);
        end
      end
    end
  endtask

  task automatic test_phase_sync();
    write_tw(1, 24'h400000);
    for (int f = 0; f < 5; f++) begin
      model_frame(f == 3);
      run_frame(f == 3, 1'b0, 0, '0, -1, 0, '0, -1);
      for (int i = 0; i < NUM_CH; i++) begin
        n_cmp++;
        if (c_sin[i+2] !== e_sin[i] || c_cos[i+2] !== e_cos[i]) begin
          n_bad++;
          $display("FAIL sync_f%0d_ch%0d got %0d %0d want %0d %0d",
                   f, i, c_sin[i+2], c_cos[i+2], e_sin[i], e_cos[i]);
        end
      end
      if (f >= 3) begin
        n_cmp++;
        if (c_sin[3] !== ((f == 3) ? 402 : 131070)) begin
          n_bad++;
          $display("FAIL sync_ch1_f%0d got %0d want %0d",
                   f, c_sin[3], (f == 3) ? 402 : 131070);
        end
      end
    end
  endtask

  task automatic test_tw_write();
    // ch3 written on the accepting edge, ch2 written mid-frame
    m_sh[3] = 24'h400000;
    model_frame(1'b0);
    run_frame(1'b0, 1'b1, 3, 24'h400000, 1, 2, 24'h200000, -1);
    m_sh[2] = 24'h200000;
    n_cmp++;
    if (c_sin[4] !== 402 || c_sin[5] !== 402) begin
      n_bad++;
      $display("FAIL tww_f0 got ch2=%0d ch3=%0d want 402 402",
               c_sin[4], c_sin[5]);
    end
    for (int f = 0; f < 3; f++) begin
      model_frame(1'b0);
      run_frame(1'b0, 1'b0, 0, '0, -1, 0, '0, -1);
      for (int i = 0; i < NUM_CH; i++) begin
        n_cmp++;
        if (c_sin[i+2] !== e_sin[i] || c_cos[i+2] !== e_cos[i]) begin
          n_bad++;
          $display("FAIL tww_f%0d_ch%0d got %0d %0d want %0d %0d",
                   f + 1, i, c_sin[i+2], c_cos[i+2], e_sin[i], e_cos[i]);
        end
      end
      if (f == 0) begin
        n_cmp++;
        if (c_sin[5] !== 131070) begin
          n_bad++;
          $display("FAIL tww_ch3_commit got %0d want 131070", c_sin[5]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    model_frame(1'b0);
    run_frame(1'b0, 1'b0, 0, '0, -1, 0, '0, 1);
    n_cmp++;
    if (c_ovr[1] !== 1'b0 || c_ovr[2] !== 1'b1 || c_ovr[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_pulse got %b%b%b want 010",
               c_ovr[1], c_ovr[2], c_ovr[3]);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      n_cmp++;
      if (c_sin[i+2] !== e_sin[i] || c_ch[i+2] !== i) begin
        n_bad++;
        $display("FAIL ovr_ch%0d got %0d ch=%0d want %0d",
                 i, c_sin[i+2], c_ch[i+2], e_sin[i]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL ovr_idle%0d got v=%b b=%b want 0 0",
                 c, valid_out, busy);
      end
    end
    model_frame(1'b0);
    run_frame(1'b0, 1'b0, 0, '0, -1, 0, '0, -1);
    for (int i = 0; i < NUM_CH; i++) begin
      n_cmp++;
      if (c_sin[i+2] !== e_sin[i] || c_cos[i+2] !== e_cos[i]) begin
        n_bad++;
        $display("FAIL ovr_next_ch%0d got %0d %0d want %0d %0d",
                 i, c_sin[i+2], c_cos[i+2], e_sin[i], e_cos[i]);
      end
    end
  endtask

  task automatic test_random();
    int nw;
    int wc;
    logic [ACC_W-1:0] d;
    bit s;
    for (int f = 0; f < 24; f++) begin
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++) begin
        wc = int'($urandom_range(0, NUM_CH - 1));
        d  = ACC_W'($urandom);
        write_tw(wc, d);
      end
      s = ($urandom_range(0, 4) == 0);
      model_frame(s);
      run_frame(s, 1'b0, 0, '0, -1, 0, '0, -1);
      for (int i = 0; i < NUM_CH; i++) begin
        n_cmp++;
        if (c_v[i+2] !== 1'b1 || c_ch[i+2] !== i ||
            c_sin[i+2] !== e_sin[i] || c_cos[i+2] !== e_cos[i]) begin
          n_bad++;
          $display("FAIL rand_f%0d_ch%0d got v=%b ch=%0d %0d %0d want %0d %0d",
                   f, i, c_v[i+2], c_ch[i+2], c_sin[i+2], c_cos[i+2],
                   e_sin[i], e_cos[i]);
        end
      end
      n_cmp++;
      if (c_v[NC-1] !== 1'b0 || c_ch[NC-1] !== NUM_CH - 1 ||
          c_sin[NC-1] !== e_sin[NUM_CH-1] ||
          c_cos[NC-1] !== e_cos[NUM_CH-1]) begin
        n_bad++;
        $display("FAIL rand_hold_f%0d got v=%b ch=%0d %0d %0d",
                 f, c_v[NC-1], c_ch[NC-1], c_sin[NC-1], c_cos[NC-1]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    sample_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      sample_en = 1'b0;
    end
    n_cmp++;
    if (valid_out !== 1'b1 || out_ch !== 2'd2) begin
      n_bad++;
      $display("FAIL rst_pre got v=%b ch=%0d want 1 2", valid_out, out_ch);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || sine_out !== 0 ||
        cosine_out !== 0 || out_ch !== 0) begin
      n_bad++;
      $display("FAIL rst_now got v=%b b=%b s=%0d c=%0d ch=%0d want zeros",
               valid_out, busy, sine_out, cosine_out, out_ch);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_hold%0d got v=%b want 0", c, valid_out);
      end
    end
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_abort%0d got v=%b want 0", c, valid_out);
      end
    end
    model_frame(1'b0);
    run_frame(1'b0, 1'b0, 0, '0, -1, 0, '0, -1);
    for (int i = 0; i < NUM_CH; i++) begin
      n_cmp++;
      if (c_v[i+2] !== 1'b1 || c_ch[i+2] !== i ||
          c_sin[i+2] !== 402 || c_cos[i+2] !== 131070) begin
        n_bad++;
        $display("FAIL rst_after_ch%0d got v=%b ch=%0d %0d %0d want 402 131070",
                 i, c_v[i+2], c_ch[i+2], c_sin[i+2], c_cos[i+2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_tw();
    test_quarter();
    test_phase_sync();
    test_tw_write();
    test_overrun();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
